fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning byte width read from the upstream FIFO.
REQ-002 The block SHALL have parameter CLK_DIV, default 16, meaning clk cycles per serial bit; legal range 2..65535.
REQ-003 The block SHALL have port clk, input, 1, the clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: synchronous, active-low.
REQ-005 The block SHALL have port fifo_empty, input, 1, meaning the FIFO holds no data.
REQ-006 The block SHALL have port fifo_data, input, DATA_W, meaning FIFO read data, valid on the cycle after fifo_r_en.
REQ-007 The block SHALL have port fifo_r_en, output, 1, meaning a one-cycle FIFO read strobe.
REQ-008 The block SHALL have port tx, output, 1, meaning the serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-010 The block SHALL have port tx_done, output, 1, meaning a one-cycle pulse at the end of each frame's stop bit.

Function
REQ-011 The FSM SHALL have states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-012 From IDLE, fifo_empty=0 SHALL cause a transition to FETCH; fifo_empty=1 SHALL keep the FSM in IDLE.
REQ-013 fifo_r_en SHALL be 1 only in FETCH, for exactly one cycle per byte, and SHALL never be asserted while fifo_empty=1.
REQ-014 FETCH SHALL go to LOAD; LOAD SHALL capture fifo_data into the shift register and go to START.
REQ-015 tx SHALL fall on the third rising edge after the edge that sampled fifo_empty=0 in IDLE.
REQ-016 START SHALL drive tx=0 for CLK_DIV cycles.
REQ-017 DATA SHALL drive DATA_W bits LSB first, each for CLK_DIV cycles, using a bit counter of width clog2(DATA_W).
REQ-018 STOP SHALL drive tx=1 for CLK_DIV cycles.
REQ-019 On the last STOP cycle, tx_done SHALL be 1; the FSM SHALL then go to FETCH if fifo_empty=0, otherwise to IDLE.
REQ-020 Back-to-back bytes SHALL have exactly 2 idle-high cycles (FETCH, LOAD) between the stop bit and the next start bit.
REQ-021 The baud counter SHALL reload to 0 on every state change and SHALL wrap at CLK_DIV-1, never overflowing.
REQ-022 A change in fifo_data or fifo_empty during START, DATA, PARITY or STOP SHALL have no effect on the frame in progress.

Reset
REQ-023 With rst=0 at a clock edge, the block SHALL set state=IDLE, tx=1, busy=0, fifo_r_en=0, tx_done=0 and clear all counters and the shift register.
REQ-024 A reset mid-frame SHALL abort the frame, with tx high from the next edge; the aborted byte is lost and is not re-read.

Configuration
REQ-025 With macro FIFO_UART_TX_PARITY_EN defined, DATA SHALL go to PARITY, which drives even parity (XOR of the byte) for CLK_DIV cycles, then goes to STOP; the frame is 11*CLK_DIV cycles.
REQ-026 Without FIFO_UART_TX_PARITY_EN, the PARITY state and logic SHALL be absent, DATA SHALL go directly to STOP, and the frame is 10*CLK_DIV cycles.

Structure
REQ-027 The shared package SHALL hold the state encoding typedef, IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1 and the default CLK_DIV.
REQ-028 Bit timing SHALL be in a sub-module uart_baud_cnt (clear input, tick output at count CLK_DIV-1); the FSM and shift register SHALL stay in fifo_uart_tx.

Verification
REQ-029 Reset test: hold rst=0 for 2 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_r_en=0 throughout.
REQ-030 Single byte test: CLK_DIV=4, one byte 8'hA5 -> one fifo_r_en pulse; tx = 0,1,0,1,0,0,1,0,1 with 4 cycles per bit; one tx_done pulse; back to IDLE.
REQ-031 Burst test: 4 bytes 8'h24, 8'h81, 8'h09, 8'h63 pre-loaded -> 4 fifo_r_en pulses; frames separated by exactly 2 high cycles; bytes decoded in order.
REQ-032 Empty test: fifo_empty=1 for 100 cycles -> fifo_r_en never asserted, tx=1, busy=0.
REQ-033 Mid-frame reset test: rst=0 during DATA bit 3 of 8'hFF -> tx=1 next edge, IDLE; with fifo_empty=0 after release, the next FIFO byte is fetched.
REQ-034 Parity test (FIFO_UART_TX_PARITY_EN defined): 8'h07 -> parity bit 1; 8'h03 -> parity bit 0; frame is 44 cycles at CLK_DIV=4.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Optional parity stage enabled by defining FIFO_UART_TX_PARITY_EN.
package fifo_uart_tx_pkg;

   localparam logic        IDLE_LEVEL      = 1'b1;
   localparam logic        START_LEVEL     = 1'b0;
   localparam logic        STOP_LEVEL      = 1'b1;
   localparam int unsigned DEFAULT_CLK_DIV = 16;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick marks the last clk cycle of each serial bit.
module uart_baud_cnt
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst || clear || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a FIFO (1-cycle read latency).
// Build option FIFO_UART_TX_PARITY_EN adds an even parity bit before stop.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_r_en,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] shift_reg;
   logic [BIT_W-1:0]  bit_cnt;
   logic              tick;
   logic              last_bit;
   logic              tx_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              par_bit;
`endif

   uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (state_nxt != state),
      .tick  (tick)
   );

   assign last_bit = (bit_cnt == BIT_W'(DATA_W - 1));
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt = state;
      fifo_r_en = 1'b0;
      tx_done   = 1'b0;
      tx_nxt    = IDLE_LEVEL;
      case (state)
         IDLE:  if (!fifo_empty) state_nxt = FETCH;
         FETCH: begin
            if (fifo_empty)
               state_nxt = IDLE;
            else begin
               fifo_r_en = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD:  state_nxt = START;
         START: begin
            tx_nxt = START_LEVEL;
            if (tick) state_nxt = DATA;
         end
         DATA: begin
            tx_nxt = shift_reg[0];
`ifdef FIFO_UART_TX_PARITY_EN
            if (tick && last_bit) state_nxt = PARITY;
`else
            if (tick && last_bit) state_nxt = STOP;
`endif
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: begin
            tx_nxt = par_bit;
            if (tick) state_nxt = STOP;
         end
`endif
         STOP: begin
            tx_nxt = STOP_LEVEL;
            if (tick) begin
               tx_done   = 1'b1;
               state_nxt = fifo_empty ? IDLE : FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // tx is registered from the current state, so the line trails the FSM by
   // one cycle: start edge lands on the third edge after leaving IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx        <= IDLE_LEVEL;
         shift_reg <= '0;
         bit_cnt   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         tx <= tx_nxt;
         if (state == LOAD) begin
            shift_reg <= fifo_data;
            bit_cnt   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_bit   <= ^fifo_data;
`endif
         end else if (state == DATA && tick) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, serial-line decoder and byte scoreboard.
// Follows FIFO_UART_TX_PARITY_EN to pick the expected frame layout.
module tb_fifo_uart_tx;

   localparam int unsigned CD = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int unsigned NB = 11;
`else
   localparam int unsigned NB = 10;
`endif

   logic       clk        = 1'b0;
   logic       rst        = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data  = 8'h00;
   logic       fifo_r_en;
   logic       tx;
   logic       busy;
   logic       tx_done;

   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_W(8), .CLK_DIV(CD)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_r_en  (fifo_r_en),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   int         gap_q[$];
   logic       par_q[$];
   int         frames_seen = 0;
   int         ren_cnt     = 0;
   int         done_cnt    = 0;
   int         ren_empty   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // FIFO with one-cycle read latency; data bus is garbage when not just read
   initial begin : fifo_model
      logic rd;
      forever begin
         @(negedge clk);
         rd = fifo_r_en;
         @(posedge clk);
         #1;
         if (rd && fifo_q.size() > 0)
            fifo_data = fifo_q.pop_front();
         else
            fifo_data = 8'($urandom);
         fifo_empty = (fifo_q.size() == 0);
      end
   end

   initial begin : strobe_counter
      forever begin
         @(negedge clk);
         if (fifo_r_en === 1'b1) begin
            ren_cnt++;
            if (fifo_empty) ren_empty++;
         end
         if (tx_done === 1'b1) done_cnt++;
      end
   end

   // Serial decoder: checks every cycle of each frame against the scoreboard byte
   initial begin : line_monitor
      logic        tx_prev = 1'b1;
      logic        completed = 1'b0;
      int          high_cnt = 0;
      logic [7:0]  exp_b, dec;
      logic [10:0] fr;
      int          bad;
      logic        aborted;
      forever begin
         @(negedge clk);
         if (!rst) begin
            completed = 1'b0;
         end else if (tx_prev === 1'b1 && tx === 1'b0) begin
            if (completed) gap_q.push_back(high_cnt);
            if (exp_q.size() == 0) begin
               chk("frame_expected", 0, 1);
               exp_b = 8'h00;
            end else
               exp_b = exp_q.pop_front();
`ifdef FIFO_UART_TX_PARITY_EN
            fr = {1'b1, ^exp_b, exp_b, 1'b0};
`else
            fr = {1'b0, 1'b1, exp_b, 1'b0};
`endif
            bad = 0;
            aborted = 1'b0;
            dec = 8'h00;
            for (int i = 0; i < int'(NB * CD); i++) begin
               if (i > 0) @(negedge clk);
               if (!rst) begin
                  aborted = 1'b1;
                  break;
               end
               if (tx !== fr[i / CD]) bad++;
               if (i % CD == CD / 2) begin
                  if (i / CD >= 1 && i / CD <= 8) dec[i / CD - 1] = tx;
                  if (i / CD == 9 && NB == 11) par_q.push_back(tx);
               end
            end
            if (!aborted) begin
               chk("frame_byte", dec, exp_b);
               chk("frame_cycle_errors", bad, 0);
               frames_seen++;
               completed = 1'b1;
            end else
               completed = 1'b0;
            high_cnt = 0;
         end else if (tx === 1'b1) begin
            high_cnt++;
         end
         tx_prev = tx;
      end
   end

   task automatic wait_frames(input int target);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (frames_seen >= target && !busy) break;
      end
      chk("frames_seen", frames_seen, target);
   endtask

   initial begin : main
      int n, v, base_ren, base_done, base_frames;

      // reset held with a non-empty FIFO
      fifo_q.push_back(8'hA5);
      exp_q.push_back(8'hA5);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!fifo_empty) break;
      end
      chk("fifo_nonempty_in_reset", fifo_empty, 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_tx", tx, 1);
         chk("rst_busy", busy, 0);
         chk("rst_r_en", fifo_r_en, 0);
      end

      // single byte, start-edge latency
      rst = 1'b1;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n++;
         if (tx === 1'b0) break;
      end
      chk("start_latency", n, 4);
      wait_frames(1);
      chk("single_r_en_pulses", ren_cnt, 1);
      chk("single_tx_done", done_cnt, 1);
      chk("single_idle_busy", busy, 0);

      // empty FIFO for 100 cycles
      v = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (fifo_r_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) v++;
      end
      chk("empty_violations", v, 0);
      chk("empty_r_en_pulses", ren_cnt, 1);

      // burst of four pre-loaded bytes
      gap_q.delete();
      base_ren  = ren_cnt;
      base_done = done_cnt;
      foreach (fifo_q[i]) fifo_q.delete(i);
      fifo_q.push_back(8'h24); exp_q.push_back(8'h24);
      fifo_q.push_back(8'h81); exp_q.push_back(8'h81);
      fifo_q.push_back(8'h09); exp_q.push_back(8'h09);
      fifo_q.push_back(8'h63); exp_q.push_back(8'h63);
      wait_frames(5);
      chk("burst_r_en_pulses", ren_cnt - base_ren, 4);
      chk("burst_tx_done", done_cnt - base_done, 4);
      chk("burst_gap_count", gap_q.size(), 4);
      if (gap_q.size() == 4)
         for (int i = 1; i < 4; i++) chk("burst_gap", gap_q[i], 2);
      chk("burst_scoreboard_empty", exp_q.size(), 0);

      // reset during data bit 3 of 8'hFF, then the next byte must follow
      base_ren    = ren_cnt;
      base_frames = frames_seen;
      fifo_q.push_back(8'hFF); exp_q.push_back(8'hFF);
      fifo_q.push_back(8'h3C); exp_q.push_back(8'h3C);
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (tx === 1'b0) break;
      end
      repeat (16) @(negedge clk);
      chk("abort_bit3_level", tx, 1);
      chk("abort_busy_before", busy, 1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_tx_high", tx, 1);
      chk("abort_busy", busy, 0);
      chk("abort_r_en", fifo_r_en, 0);
      @(negedge clk);
      rst = 1'b1;
      wait_frames(base_frames + 1);
      chk("abort_r_en_pulses", ren_cnt - base_ren, 2);
      chk("abort_scoreboard_empty", exp_q.size(), 0);

      // parity-sensitive bytes
      base_frames = frames_seen;
      par_q.delete();
      fifo_q.push_back(8'h07); exp_q.push_back(8'h07);
      fifo_q.push_back(8'h03); exp_q.push_back(8'h03);
      wait_frames(base_frames + 2);
`ifdef FIFO_UART_TX_PARITY_EN
      chk("parity_count", par_q.size(), 2);
      if (par_q.size() == 2) begin
         chk("parity_07", par_q[0], 1);
         chk("parity_03", par_q[1], 0);
      end
`else
      chk("no_parity_samples", par_q.size(), 0);
`endif
      chk("r_en_while_empty", ren_empty, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
